wash_bay_scheduler: RTL and testbench

- Shares a pool of washing-machine controllers between a stream of paid wash requests from the coin acceptor front end.
- Queues each request (single or double wash) and selects an idle machine by round-robin.
- Drives that machine's coin_in and double_wash for a fixed pulse, then confirms the machine started (wash_done falls).
- Sits between the coin acceptor and N instances of the washing machine top.

---
 rtl/wash_sched_pkg.sv | 26 ++
 rtl/wash_bay_scheduler_if.sv | 30 +++
 rtl/wash_req_fifo.sv | 61 ++++++
 rtl/wash_bay_scheduler.sv | 165 ++++++++++++++++
 tb/tb_wash_bay_scheduler.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wash_sched_pkg.sv
// Shared types and width helpers for the wash bay scheduler slice.
package wash_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        ACK   = 2'b10
    } sched_state_e;

    // Timer widths cover the largest legal COIN_PULSE_CYCLES (15) and ACK_TIMEOUT (255).
    localparam int PULSE_CNT_W = 4;
    localparam int ACK_CNT_W   = 8;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 32'sd0;
        remain = value - 32'sd1;
        while (remain > 32'sd0) begin
            result = result + 32'sd1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wash_bay_scheduler_if.sv
// Request, machine-pool and status bundle between the coin front end, machines and scheduler.
interface wash_bay_scheduler_if #(
    parameter int NUM_MACHINES = 4,
    parameter int QUEUE_DEPTH  = 4
);
    localparam int ID_W  = wash_sched_pkg::clog2(NUM_MACHINES);
    localparam int CNT_W = wash_sched_pkg::clog2(QUEUE_DEPTH + 1);

    logic                    req_valid;
    logic                    req_double;
    logic                    req_ready;
    logic [NUM_MACHINES-1:0] mach_done;
    logic [NUM_MACHINES-1:0] mach_coin;
    logic [NUM_MACHINES-1:0] mach_double;
    logic                    grant_valid;
    logic [ID_W-1:0]         grant_id;
    logic [CNT_W-1:0]        queue_count;
    logic [NUM_MACHINES-1:0] fault_mask;

    modport master (
        output req_valid, req_double, mach_done,
        input  req_ready, mach_coin, mach_double, grant_valid, grant_id, queue_count, fault_mask
    );

    modport slave (
        input  req_valid, req_double, mach_done,
        output req_ready, mach_coin, mach_double, grant_valid, grant_id, queue_count, fault_mask
    );

endinterface

// File: rtl/wash_req_fifo.sv
// Pending wash request queue: one bit per entry (double-wash flag), drop-on-full push.
module wash_req_fifo
    import wash_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          push_data,
    input  logic                          pop,
    output logic                          pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [clog2(DEPTH + 1)-1:0]   count
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full     = (count_r == CW'(DEPTH));
    assign empty    = (count_r == {CW{1'b0}});
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];

    // Qualify requests so a full push or empty pop never moves a pointer.
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
    end

    // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r    <= {DEPTH{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wash_bay_scheduler.sv
// Hands queued paid washes to idle machines round-robin, pulses coin_in and confirms start.
module wash_bay_scheduler
    import wash_sched_pkg::*;
#(
    parameter int NUM_MACHINES      = 4,
    parameter int QUEUE_DEPTH       = 4,
    parameter int COIN_PULSE_CYCLES = 2,
    parameter int ACK_TIMEOUT       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    wash_bay_scheduler_if.slave  bus
);
    localparam int ID_W = clog2(NUM_MACHINES);
    localparam int CW   = clog2(QUEUE_DEPTH + 1);
    localparam logic [NUM_MACHINES-1:0] ONE_HOT_0 = {{(NUM_MACHINES-1){1'b0}}, 1'b1};
    localparam logic [PULSE_CNT_W-1:0]  PULSE_LAST = PULSE_CNT_W'(COIN_PULSE_CYCLES - 1);
    localparam logic [ACK_CNT_W-1:0]    ACK_LAST   = ACK_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [ID_W-1:0]         LAST_ID    = ID_W'(NUM_MACHINES - 1);

    sched_state_e            state_r, state_nxt_s;
    logic [ID_W-1:0]         grant_id_r, grant_id_nxt_s;
    logic [ID_W-1:0]         rr_ptr_r, rr_ptr_nxt_s;
    logic [ID_W-1:0]         next_ptr_s;
    logic [ID_W-1:0]         cand_s;
    logic [ID_W-1:0]         sel_id_s;
    logic                    sel_found_s;
    logic                    dbl_r, dbl_nxt_s;
    logic [PULSE_CNT_W-1:0]  pulse_cnt_r, pulse_cnt_nxt_s;
    logic [ACK_CNT_W-1:0]    ack_cnt_r, ack_cnt_nxt_s;
    logic [NUM_MACHINES-1:0] fault_r, fault_nxt_s;
    logic [NUM_MACHINES-1:0] coin_r, coin_nxt_s;
    logic [NUM_MACHINES-1:0] double_r, double_nxt_s;
    logic [NUM_MACHINES-1:0] elig_s;
    logic                    grant_valid_r, grant_valid_nxt_s;
    logic                    pop_s;
    logic                    fifo_head_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [CW-1:0]           fifo_count_s;

    wash_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.req_valid),
        .push_data (bus.req_double),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign bus.req_ready   = ~fifo_full_s;
    assign bus.queue_count = fifo_count_s;
    assign bus.mach_coin   = coin_r;
    assign bus.mach_double = double_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.fault_mask  = fault_r;

    // Round-robin pick: first idle, unfaulted machine at or after the pointer.
    always_comb begin
        elig_s      = bus.mach_done & ~fault_r;
        sel_found_s = 1'b0;
        sel_id_s    = {ID_W{1'b0}};
        cand_s      = {ID_W{1'b0}};
        for (int k = 32'sd0; k < NUM_MACHINES; k++) begin
            cand_s = ID_W'((int'(rr_ptr_r) + k) % NUM_MACHINES);
            if (!sel_found_s && elig_s[cand_s]) begin
                sel_found_s = 1'b1;
                sel_id_s    = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        next_ptr_s = (grant_id_r == LAST_ID) ? {ID_W{1'b0}} : grant_id_r + 1'b1;
    end

    // Scheduler next state; pulse outputs are precomputed here so they leave on flops.
    always_comb begin
        state_nxt_s       = state_r;
        grant_id_nxt_s    = grant_id_r;
        rr_ptr_nxt_s      = rr_ptr_r;
        dbl_nxt_s         = dbl_r;
        pulse_cnt_nxt_s   = pulse_cnt_r;
        ack_cnt_nxt_s     = ack_cnt_r;
        fault_nxt_s       = fault_r;
        grant_valid_nxt_s = 1'b0;
        pop_s             = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && sel_found_s) begin
                    state_nxt_s     = PULSE;
                    grant_id_nxt_s  = sel_id_s;
                    dbl_nxt_s       = fifo_head_s;
                    pulse_cnt_nxt_s = {PULSE_CNT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PULSE: begin
                if (pulse_cnt_r == PULSE_LAST) begin
                    state_nxt_s   = ACK;
                    ack_cnt_nxt_s = {ACK_CNT_W{1'b0}};
                end else begin
                    pulse_cnt_nxt_s = pulse_cnt_r + 1'b1;
                end
            end
            ACK: begin
                if (!bus.mach_done[grant_id_r]) begin
                    pop_s             = 1'b1;
                    grant_valid_nxt_s = 1'b1;
                    rr_ptr_nxt_s      = next_ptr_s;
                    state_nxt_s       = IDLE;
                end else if (ack_cnt_r == ACK_LAST) begin
                    // Request stays queued so another machine can take it.
                    fault_nxt_s[grant_id_r] = 1'b1;
                    rr_ptr_nxt_s            = next_ptr_s;
                    state_nxt_s             = IDLE;
                end else begin
                    ack_cnt_nxt_s = ack_cnt_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (state_nxt_s == PULSE) begin
            coin_nxt_s   = ONE_HOT_0 << grant_id_nxt_s;
            double_nxt_s = coin_nxt_s & {NUM_MACHINES{dbl_nxt_s}};
        end else begin
            coin_nxt_s   = {NUM_MACHINES{1'b0}};
            double_nxt_s = {NUM_MACHINES{1'b0}};
        end
    end

    // Scheduler state and registered outputs; reset drops any pulse in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            grant_id_r    <= {ID_W{1'b0}};
            rr_ptr_r      <= {ID_W{1'b0}};
            dbl_r         <= 1'b0;
            pulse_cnt_r   <= {PULSE_CNT_W{1'b0}};
            ack_cnt_r     <= {ACK_CNT_W{1'b0}};
            fault_r       <= {NUM_MACHINES{1'b0}};
            coin_r        <= {NUM_MACHINES{1'b0}};
            double_r      <= {NUM_MACHINES{1'b0}};
            grant_valid_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            grant_id_r    <= grant_id_nxt_s;
            rr_ptr_r      <= rr_ptr_nxt_s;
            dbl_r         <= dbl_nxt_s;
            pulse_cnt_r   <= pulse_cnt_nxt_s;
            ack_cnt_r     <= ack_cnt_nxt_s;
            fault_r       <= fault_nxt_s;
            coin_r        <= coin_nxt_s;
            double_r      <= double_nxt_s;
            grant_valid_r <= grant_valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_wash_bay_scheduler.sv
// Directed bench for wash_bay_scheduler with a simple washing-machine response model.
module tb_wash_bay_scheduler;
    localparam int NM   = 4;
    localparam int WASH = 12;

    logic clk;
    logic rst;
    logic [NM-1:0] done_model;
    logic [NM-1:0] busy_force;
    logic [NM-1:0] stuck;
    logic [NM-1:0] coin_prev;
    logic [NM-1:0] mon_coin_prev;
    int dly  [0:NM-1];
    int busy [0:NM-1];
    int n_checks;
    int n_errors;

    logic [NM-1:0] coin_q[$];
    logic [NM-1:0] dbl_q[$];
    logic [1:0]    gid_q[$];

    wash_bay_scheduler_if #(.NUM_MACHINES(NM), .QUEUE_DEPTH(4)) bus ();

    wash_bay_scheduler #(
        .NUM_MACHINES(NM), .QUEUE_DEPTH(4), .COIN_PULSE_CYCLES(2), .ACK_TIMEOUT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mach_done = done_model & ~busy_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Machine model: done falls 3 cycles after coin rises, stays low WASH cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            done_model <= {NM{1'b1}};
            coin_prev  <= {NM{1'b0}};
            for (int i = 0; i < NM; i++) begin
                dly[i]  <= 0;
                busy[i] <= 0;
            end
        end else begin
            coin_prev <= bus.mach_coin;
            for (int i = 0; i < NM; i++) begin
                if (bus.mach_coin[i] && !coin_prev[i] && !stuck[i]) begin
                    dly[i] <= 2;
                end else if (dly[i] == 1) begin
                    dly[i]        <= 0;
                    done_model[i] <= 1'b0;
                    busy[i]       <= WASH;
                end else if (dly[i] > 1) begin
                    dly[i] <= dly[i] - 1;
                end else if (busy[i] == 1) begin
                    busy[i]       <= 0;
                    done_model[i] <= 1'b1;
                end else if (busy[i] > 1) begin
                    busy[i] <= busy[i] - 1;
                end
            end
        end
    end

    // Record each coin pulse start and each acknowledged grant.
    always @(negedge clk) begin
        if (!rst && bus.mach_coin != '0 && mon_coin_prev == '0) begin
            coin_q.push_back(bus.mach_coin);
            dbl_q.push_back(bus.mach_double);
        end
        if (!rst && bus.grant_valid) gid_q.push_back(bus.grant_id);
        mon_coin_prev <= bus.mach_coin;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_double = 1'b0;
        busy_force     = '0;
        stuck          = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
        coin_q.delete();
        dbl_q.delete();
        gid_q.delete();
    endtask

    task automatic push_one(input logic dbl);
        bus.req_valid  = 1'b1;
        bus.req_double = dbl;
        tick(1);
        bus.req_valid  = 1'b0;
    endtask

    initial begin
        logic [NM-1:0] exp_coin [0:3];
        logic [NM-1:0] exp_dbl  [0:3];
        logic          pat      [0:4];
        int hits;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_double = 1'b0;
        busy_force = '0;
        stuck      = '0;
        tick(2);
        check_eq("rst_coin",   32'(bus.mach_coin), 32'h0);
        check_eq("rst_double", 32'(bus.mach_double), 32'h0);
        check_eq("rst_gv",     32'(bus.grant_valid), 32'h0);
        check_eq("rst_gid",    32'(bus.grant_id), 32'h0);
        check_eq("rst_fault",  32'(bus.fault_mask), 32'h0);
        check_eq("rst_count",  32'(bus.queue_count), 32'h0);
        check_eq("rst_ready",  32'(bus.req_ready), 32'h1);
        rst = 1'b0;
        tick(1);

        // Reset mid-pulse
        push_one(1'b1);
        tick(1);
        check_eq("mid_coin_pre", 32'(bus.mach_coin), 32'h1);
        rst = 1'b1;
        #1;
        check_eq("mid_coin",   32'(bus.mach_coin), 32'h0);
        check_eq("mid_double", 32'(bus.mach_double), 32'h0);
        check_eq("mid_count",  32'(bus.queue_count), 32'h0);
        check_eq("mid_ready",  32'(bus.req_ready), 32'h1);
        check_eq("mid_gv",     32'(bus.grant_valid), 32'h0);

        // Single request, exact latency
        do_reset();
        push_one(1'b0);
        check_eq("s_count1", 32'(bus.queue_count), 32'h1);
        check_eq("s_coin_p0", 32'(bus.mach_coin), 32'h0);
        tick(1);
        check_eq("s_coin_p1", 32'(bus.mach_coin), 32'h1);
        check_eq("s_dbl_p1",  32'(bus.mach_double), 32'h0);
        tick(1);
        check_eq("s_coin_p2", 32'(bus.mach_coin), 32'h1);
        tick(1);
        check_eq("s_coin_p3", 32'(bus.mach_coin), 32'h0);
        tick(1);
        check_eq("s_gv_p4",   32'(bus.grant_valid), 32'h0);
        tick(1);
        check_eq("s_gv_p5",   32'(bus.grant_valid), 32'h1);
        check_eq("s_gid_p5",  32'(bus.grant_id), 32'h0);
        check_eq("s_count0",  32'(bus.queue_count), 32'h0);
        tick(1);
        check_eq("s_gv_p6",   32'(bus.grant_valid), 32'h0);

        // Round robin with double wash
        do_reset();
        push_one(1'b1);
        push_one(1'b0);
        push_one(1'b1);
        tick(40);
        check_eq("rr_ngrant", 32'(gid_q.size()), 32'd3);
        check_eq("rr_gid0", 32'(gid_q[0]), 32'd0);
        check_eq("rr_gid1", 32'(gid_q[1]), 32'd1);
        check_eq("rr_gid2", 32'(gid_q[2]), 32'd2);
        check_eq("rr_dbl0", 32'(dbl_q[0]), 32'h1);
        check_eq("rr_dbl1", 32'(dbl_q[1]), 32'h0);
        check_eq("rr_dbl2", 32'(dbl_q[2]), 32'h4);
        check_eq("rr_count", 32'(bus.queue_count), 32'h0);

        // FIFO full with all machines busy; fifth push dropped
        do_reset();
        busy_force = 4'b1111;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_one(pat[i]);
            check_eq($sformatf("full_count%0d", i), 32'(bus.queue_count), (i < 4) ? 32'(i + 1) : 32'd4);
            if (i == 3) check_eq("full_ready", 32'(bus.req_ready), 32'h0);
        end
        check_eq("full_nocoin", 32'(bus.mach_coin), 32'h0);
        busy_force = 4'b0111;
        tick(12);
        check_eq("full_ngrant", 32'(gid_q.size()), 32'd1);
        check_eq("full_gid3",   32'(gid_q[0]), 32'd3);
        check_eq("full_count3", 32'(bus.queue_count), 32'd3);
        busy_force = 4'b0000;
        tick(60);
        exp_coin[0] = 4'b1000; exp_coin[1] = 4'b0001; exp_coin[2] = 4'b0010; exp_coin[3] = 4'b0100;
        exp_dbl[0]  = 4'b1000; exp_dbl[1]  = 4'b0000; exp_dbl[2]  = 4'b0010; exp_dbl[3]  = 4'b0100;
        check_eq("full_ncoin", 32'(coin_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("full_coin%0d", i), 32'(coin_q[i]), 32'(exp_coin[i]));
            check_eq($sformatf("full_dbl%0d", i),  32'(dbl_q[i]),  32'(exp_dbl[i]));
        end
        check_eq("full_drain", 32'(bus.queue_count), 32'd0);

        // Timeout on machine 1, retry on machine 2
        do_reset();
        busy_force = 4'b0001;
        stuck      = 4'b0010;
        push_one(1'b0);
        tick(10);
        check_eq("to_fault_p10", 32'(bus.fault_mask), 32'h0);
        check_eq("to_count_p10", 32'(bus.queue_count), 32'h1);
        tick(1);
        check_eq("to_fault_p11", 32'(bus.fault_mask), 32'h2);
        check_eq("to_count_p11", 32'(bus.queue_count), 32'h1);
        check_eq("to_gv_p11",    32'(bus.grant_valid), 32'h0);
        tick(1);
        check_eq("to_retry_coin", 32'(bus.mach_coin), 32'h4);
        tick(10);
        check_eq("to_retry_gid", 32'(gid_q[0]), 32'd2);
        check_eq("to_count0",    32'(bus.queue_count), 32'h0);
        busy_force = 4'b0000;
        push_one(1'b0);
        push_one(1'b1);
        push_one(1'b0);
        tick(80);
        hits = 0;
        foreach (coin_q[i]) if (coin_q[i] == 4'b0010) hits++;
        check_eq("to_m1_coins", 32'(hits), 32'd1);
        hits = 0;
        foreach (gid_q[i]) if (gid_q[i] == 2'd1) hits++;
        check_eq("to_m1_grants", 32'(hits), 32'd0);
        check_eq("to_ngrant",    32'(gid_q.size()), 32'd4);
        check_eq("to_drain",     32'(bus.queue_count), 32'd0);

        // All machines faulted
        do_reset();
        stuck = 4'b1111;
        push_one(1'b0);
        tick(60);
        check_eq("af_fault", 32'(bus.fault_mask), 32'hf);
        check_eq("af_count1", 32'(bus.queue_count), 32'd1);
        push_one(1'b1);
        check_eq("af_count2", 32'(bus.queue_count), 32'd2);
        push_one(1'b0);
        check_eq("af_count3", 32'(bus.queue_count), 32'd3);
        tick(20);
        check_eq("af_coin",    32'(bus.mach_coin), 32'h0);
        check_eq("af_count",   32'(bus.queue_count), 32'd3);
        check_eq("af_attempts", 32'(coin_q.size()), 32'd4);
        check_eq("af_ngrant",  32'(gid_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
